// File: rtl/vxe_vpu_cmd_rcv_unit.sv
// VPU-side receiver for the CU->VPU command bus.
// Buffers accepted commands in a 2^DEPTH_POW2-entry FIFO and presents them in order
// through one registered valid/ready output stage with one-hot thread decode.
// Optional feature macro: VXE_VPU_CMD_RCV_TH_CHK_EN (drop commands for unimplemented
// threads and raise a sticky o_err).
module vxe_vpu_cmd_rcv_unit #(
  parameter int unsigned DEPTH_POW2 = 4,
  parameter int unsigned NTHREADS   = 8
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        i_vpu_cmd_sel,
  output logic        o_vpu_cmd_ack,
  input  logic [4:0]  i_vpu_cmd_op,
  input  logic [2:0]  i_vpu_cmd_th,
  input  logic [47:0] i_vpu_cmd_pl,
  output logic        o_cmd_vld,
  input  logic        i_cmd_rdy,
  output logic [4:0]  o_cmd_op,
  output logic [2:0]  o_cmd_th,
  output logic [7:0]  o_cmd_th_oh,
  output logic [47:0] o_cmd_pl,
  output logic        o_busy,
  output logic        o_err
);

  localparam int unsigned Depth = 1 << DEPTH_POW2;
  localparam int unsigned PtrW  = DEPTH_POW2 + 1;

  if (NTHREADS < 1 || NTHREADS > 8) begin : g_nthreads_chk
    $error("NTHREADS must be in 1..8");
  end

  logic            rcv_en_q;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [4:0]      mem_op [Depth];
  logic [2:0]      mem_th [Depth];
  logic [47:0]     mem_pl [Depth];

  logic fifo_empty, fifo_full;
  logic push, wr_en, pop, th_ok;

  logic [DEPTH_POW2-1:0] wr_idx, rd_idx;

  assign wr_idx = wr_ptr_q[PtrW-2:0];
  assign rd_idx = rd_ptr_q[PtrW-2:0];

  // MSB of each pointer is the wrap bit distinguishing full from empty
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) && (wr_idx == rd_idx);

  // Ack depends on registers only, so the CU sees no combinational path back from sel
  assign o_vpu_cmd_ack = rcv_en_q && !fifo_full;
  assign push          = i_vpu_cmd_sel && o_vpu_cmd_ack;

`ifdef VXE_VPU_CMD_RCV_TH_CHK_EN
  assign th_ok = (32'(i_vpu_cmd_th) < NTHREADS);
`else
  assign th_ok = 1'b1;
`endif

  // Out-of-range commands are still acked but never stored
  assign wr_en = push && th_ok;
  assign pop   = !fifo_empty && (!o_cmd_vld || i_cmd_rdy);

  assign o_busy = !fifo_empty || o_cmd_vld;

  // Receive enable: holds ack low for the first edge after reset release
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) rcv_en_q <= 1'b0;
    else       rcv_en_q <= 1'b1;
  end

  // FIFO pointers, wrapping naturally modulo 2^PtrW
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // FIFO storage; contents are don't-care while the pointers mark them empty
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_op[wr_idx] <= i_vpu_cmd_op;
      mem_th[wr_idx] <= i_vpu_cmd_th;
      mem_pl[wr_idx] <= i_vpu_cmd_pl;
    end
  end

  // Output stage: load head on pop, drop valid when consumed with nothing to refill
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      o_cmd_vld   <= 1'b0;
      o_cmd_op    <= '0;
      o_cmd_th    <= '0;
      o_cmd_th_oh <= '0;
      o_cmd_pl    <= '0;
    end else if (pop) begin
      o_cmd_vld   <= 1'b1;
      o_cmd_op    <= mem_op[rd_idx];
      o_cmd_th    <= mem_th[rd_idx];
      o_cmd_th_oh <= 8'b1 << mem_th[rd_idx];
      o_cmd_pl    <= mem_pl[rd_idx];
    end else if (o_cmd_vld && i_cmd_rdy) begin
      o_cmd_vld   <= 1'b0;
      o_cmd_th_oh <= '0;
    end
  end

`ifdef VXE_VPU_CMD_RCV_TH_CHK_EN
  logic err_q;

  // Sticky illegal-thread flag, cleared only by reset
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)              err_q <= 1'b0;
    else if (push && !th_ok) err_q <= 1'b1;
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_vxe_vpu_cmd_rcv_unit.sv
// Directed self-checking bench for vxe_vpu_cmd_rcv_unit (DEPTH_POW2 = 4).
`timescale 1ns/1ps
module tb_vxe_vpu_cmd_rcv_unit;

`ifdef VXE_VPU_CMD_RCV_TH_CHK_EN
  localparam int unsigned NTH = 4;
`else
  localparam int unsigned NTH = 8;
`endif

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        cu_sel = 1'b0;
  logic        cu_ack;
  logic [4:0]  cu_op = '0;
  logic [2:0]  cu_th = '0;
  logic [47:0] cu_pl = '0;
  logic        cmd_vld;
  logic        cmd_rdy = 1'b0;
  logic [4:0]  cmd_op;
  logic [2:0]  cmd_th;
  logic [7:0]  cmd_th_oh;
  logic [47:0] cmd_pl;
  logic        busy;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;
  int sent, recv, cyc, ack_low, first_rcv, last_rcv;

  vxe_vpu_cmd_rcv_unit #(
    .DEPTH_POW2(4),
    .NTHREADS  (NTH)
  ) dut (
    .clk          (clk),
    .nrst         (nrst),
    .i_vpu_cmd_sel(cu_sel),
    .o_vpu_cmd_ack(cu_ack),
    .i_vpu_cmd_op (cu_op),
    .i_vpu_cmd_th (cu_th),
    .i_vpu_cmd_pl (cu_pl),
    .o_cmd_vld    (cmd_vld),
    .i_cmd_rdy    (cmd_rdy),
    .o_cmd_op     (cmd_op),
    .o_cmd_th     (cmd_th),
    .o_cmd_th_oh  (cmd_th_oh),
    .o_cmd_pl     (cmd_pl),
    .o_busy       (busy),
    .o_err        (err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] gen_op(input int k);
    logic [31:0] kv;
    kv = 32'(k);
    return kv[4:0] ^ 5'h15;
  endfunction

  function automatic logic [2:0] gen_th(input int k);
    return 3'(32'(k) % NTH);
  endfunction

  function automatic logic [47:0] gen_pl(input int k);
    logic [31:0] kv;
    kv = 32'(k);
    return {kv[15:0] ^ 16'hC3A5, ~kv};
  endfunction

  // Expected {th_oh, op, th, pl} for generated command k
  function automatic logic [63:0] exp_word(input int k);
    logic [2:0] t;
    t = gen_th(k);
    return {8'b1 << t, gen_op(k), t, gen_pl(k)};
  endfunction

  function automatic logic [63:0] obs_word();
    return {cmd_th_oh, cmd_op, cmd_th, cmd_pl};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counters();
    sent = 0; recv = 0; cyc = 0; ack_low = 0; first_rcv = -1; last_rcv = -1;
  endtask

  // Offer commands base..base+n-1, count handshakes, check deliveries in order.
  // Inputs and outputs are examined 1 ns after the edge, ahead of the next edge.
  task automatic run(input int base, input int n, input int budget);
    int lim;
    lim = cyc + budget;
    while ((sent < n || recv < n) && cyc < lim) begin
      if (sent < n) begin
        cu_sel = 1'b1;
        cu_op  = gen_op(base + sent);
        cu_th  = gen_th(base + sent);
        cu_pl  = gen_pl(base + sent);
      end else begin
        cu_sel = 1'b0;
      end
      if (sent < n && !cu_ack) ack_low++;
      if (cmd_vld && cmd_rdy) begin
        check_val("deliver", obs_word(), exp_word(base + recv));
        if (first_rcv < 0) first_rcv = cyc;
        last_rcv = cyc;
        recv++;
      end
      if (cu_sel && cu_ack) sent++;
      step();
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset release with sel low
    step();
    check_val("rst_ack", 64'(cu_ack), 64'd0);
    check_val("rst_vld", 64'(cmd_vld), 64'd0);
    check_val("rst_fields", obs_word(), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_err", 64'(err), 64'd0);
    step();
    nrst = 1'b1;
    check_val("ack_first_cycle", 64'(cu_ack), 64'd0);
    step();
    check_val("ack_second_cycle", 64'(cu_ack), 64'd1);
    check_val("idle_vld", 64'(cmd_vld), 64'd0);
    check_val("idle_busy", 64'(busy), 64'd0);

    // Single command, two-edge latency
    cu_sel = 1'b1; cu_op = 5'h03; cu_th = 3'd2; cu_pl = 48'h0000_1234_5678;
    step();
    cu_sel = 1'b0;
    check_val("single_vld_e", 64'(cmd_vld), 64'd0);
    check_val("single_busy_e", 64'(busy), 64'd1);
    step();
    check_val("single_vld_e1", 64'(cmd_vld), 64'd1);
    check_val("single_fields", obs_word(), {8'h04, 5'h03, 3'd2, 48'h0000_1234_5678});
    cmd_rdy = 1'b1;
    step();
    cmd_rdy = 1'b0;
    check_val("single_consumed_vld", 64'(cmd_vld), 64'd0);
    check_val("single_consumed_oh", 64'(cmd_th_oh), 64'd0);
    check_val("single_consumed_busy", 64'(busy), 64'd0);

    // Fill to capacity (16 FIFO + 1 output stage), then drain
    clr_counters();
    run(100, 20, 25);
    check_val("fill_accepted", 64'(sent), 64'd17);
    check_val("fill_ack_low", 64'(cu_ack), 64'd0);
    check_val("fill_vld", 64'(cmd_vld), 64'd1);
    check_val("fill_busy", 64'(busy), 64'd1);
    cmd_rdy = 1'b1;
    run(100, 20, 80);
    cu_sel = 1'b0;
    check_val("drain_sent", 64'(sent), 64'd20);
    check_val("drain_recv", 64'(recv), 64'd20);
    step();
    check_val("drain_busy", 64'(busy), 64'd0);

    // Streaming at one command per cycle, pointers wrap several times
    clr_counters();
    cmd_rdy = 1'b1;
    run(1000, 100, 150);
    cu_sel = 1'b0;
    check_val("stream_recv", 64'(recv), 64'd100);
    check_val("stream_ack_drops", 64'(ack_low), 64'd0);
    check_val("stream_rate", 64'(last_rcv - first_rcv), 64'd99);
    check_val("stream_first_latency", 64'(first_rcv), 64'd2);

    // Reset with 5 commands buffered
    clr_counters();
    cmd_rdy = 1'b0;
    run(2000, 5, 8);
    cu_sel = 1'b0;
    check_val("prerst_sent", 64'(sent), 64'd5);
    check_val("prerst_busy", 64'(busy), 64'd1);
    nrst = 1'b0;
    #1;
    check_val("midrst_ack", 64'(cu_ack), 64'd0);
    check_val("midrst_vld", 64'(cmd_vld), 64'd0);
    check_val("midrst_fields", obs_word(), 64'd0);
    check_val("midrst_busy", 64'(busy), 64'd0);
    step();
    nrst = 1'b1;
    check_val("postrst_ack_first", 64'(cu_ack), 64'd0);
    step();
    check_val("postrst_ack_second", 64'(cu_ack), 64'd1);
    check_val("postrst_busy", 64'(busy), 64'd0);
    clr_counters();
    cmd_rdy = 1'b1;
    run(3000, 3, 20);
    cu_sel = 1'b0;
    check_val("postrst_recv", 64'(recv), 64'd3);
    step();
    check_val("postrst_idle", 64'(busy), 64'd0);

    // Thread-range check: th=6 followed by th=1
    check_val("err_before", 64'(err), 64'd0);
    cu_sel = 1'b1; cu_op = 5'h1F; cu_th = 3'd6; cu_pl = 48'hDEAD_BEEF_0001;
    check_val("th6_ack", 64'(cu_ack), 64'd1);
    step();
    cu_op = 5'h0A; cu_th = 3'd1; cu_pl = 48'h0000_0000_0ABC;
    check_val("th1_ack", 64'(cu_ack), 64'd1);
    step();
    cu_sel = 1'b0;
`ifdef VXE_VPU_CMD_RCV_TH_CHK_EN
    check_val("th6_dropped_vld", 64'(cmd_vld), 64'd0);
    check_val("th6_err_set", 64'(err), 64'd1);
`else
    check_val("th6_delivered", obs_word(), {8'h40, 5'h1F, 3'd6, 48'hDEAD_BEEF_0001});
    check_val("th6_no_err", 64'(err), 64'd0);
`endif
    step();
    check_val("th1_vld", 64'(cmd_vld), 64'd1);
    check_val("th1_fields", obs_word(), {8'h02, 5'h0A, 3'd1, 48'h0000_0000_0ABC});
    step();
    check_val("th_final_vld", 64'(cmd_vld), 64'd0);
    check_val("th_final_busy", 64'(busy), 64'd0);
`ifdef VXE_VPU_CMD_RCV_TH_CHK_EN
    check_val("err_sticky", 64'(err), 64'd1);
`else
    check_val("err_tied_low", 64'(err), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
